imem_loader: RTL

- Upstream stage of the instruction memory. Receives the program as 5-bit chunks ("quintets") on a valid/ready handshake and packs every three into one 15-bit instruction.
- Writes each instruction into consecutive imem locations, then checks a trailing XOR checksum quintet.
- On a checksum match, asserts `done`, which drives the CPU enable. On a mismatch, parks in an error state until restarted.

---
 rtl/imem_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Front end of the instruction memory. Takes the program as CHUNK_WIDTH-bit
//   chunks on a valid/ready handshake. It packs CHUNKS chunks into one word,
//   with the first chunk in the LSBs. It writes each word to consecutive imem
//   addresses. It then compares one trailing chunk with the running XOR of all
//   program chunks. On a match, done is raised and drives the CPU enable. On a
//   mismatch, error is raised and the loader waits for restart.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active low
//   restart   synchronous restart of the load sequence
//   in_valid  chunk present on in_chunk
//   in_chunk  program / checksum chunk
//   in_ready  chunk accepted this cycle when in_valid is high
//   wr_en     imem write strobe, one-cycle pulse
//   wr_addr   imem write address (held between writes)
//   wr_data   imem write data (held between writes)
//   done      program loaded and checksum good (level)
//   error     checksum mismatch (level)
module imem_loader #(
    parameter int INSTR_WIDTH = 15,
    parameter int CHUNK_WIDTH = 5,
    parameter int CHUNKS      = 3,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   in_valid,
    input  logic [CHUNK_WIDTH-1:0] in_chunk,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   done,
    output logic                   error
);

    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0]      LAST_CHUNK = CNT_W'(CHUNKS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CHUNK_WIDTH-1:0] csum_q;
    logic [INSTR_WIDTH-1:0] word_q;
    logic [INSTR_WIDTH-1:0] word_next;
    logic                   accept;
    logic                   last_chunk;

    assign accept     = in_valid & in_ready;
    assign last_chunk = (cnt_q == LAST_CHUNK);

    // Current word with the incoming chunk merged in. On the last chunk of a
    // word this is the complete instruction. Slots above cnt_q may hold
    // leftovers from an earlier word. Each slot is rewritten before it is
    // used, so those leftovers never reach wr_data.
    always_comb begin
        word_next = word_q;
        word_next[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = in_chunk;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_LOAD;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // The move to CHECK happens on the same edge that schedules the last
    // write. The checksum chunk can therefore follow the last program chunk
    // with no gap.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD:
                    if (accept && last_chunk && addr_q == LAST_ADDR)
                        state_d = S_CHECK;
                S_CHECK:
                    if (accept)
                        state_d = (in_chunk == csum_q) ? S_DONE : S_ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Gating with rst_n keeps these low during reset cycles, even before the
    // reset edge has reached the state register.
    always_comb begin
        in_ready = rst_n && (state_q == S_LOAD || state_q == S_CHECK);
        done     = rst_n && (state_q == S_DONE);
        error    = rst_n && (state_q == S_ERROR);
    end

    // ---------------- Datapath ----------------
    // Restart drops the chunk offered in the same cycle. A write pulse that
    // is already on wr_en this cycle has been issued, so restart does not
    // cancel it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                cnt_q  <= '0;
                addr_q <= '0;
                csum_q <= '0;
            end else if (accept && state_q == S_LOAD) begin
                csum_q <= csum_q ^ in_chunk;
                word_q <= word_next;
                if (last_chunk) begin
                    cnt_q   <= '0;
                    addr_q  <= addr_q + 1'b1;
                    wr_en   <= 1'b1;
                    wr_addr <= addr_q;
                    wr_data <= word_next;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
